// File: rtl/tron_pkg.sv
// Shared Tron definitions: command codes, direction encoding, PS/2 prefixes, key map.
// Pure declarations; no latency and no backpressure.
package tron_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Direction commands are {0, player index, direction}.
  localparam logic [4:0] CMD_P1_UP    = {1'b0, 2'd0, DIR_UP};
  localparam logic [4:0] CMD_P1_DOWN  = {1'b0, 2'd0, DIR_DOWN};
  localparam logic [4:0] CMD_P1_LEFT  = {1'b0, 2'd0, DIR_LEFT};
  localparam logic [4:0] CMD_P1_RIGHT = {1'b0, 2'd0, DIR_RIGHT};
  localparam logic [4:0] CMD_P2_UP    = {1'b0, 2'd1, DIR_UP};
  localparam logic [4:0] CMD_P2_DOWN  = {1'b0, 2'd1, DIR_DOWN};
  localparam logic [4:0] CMD_P2_LEFT  = {1'b0, 2'd1, DIR_LEFT};
  localparam logic [4:0] CMD_P2_RIGHT = {1'b0, 2'd1, DIR_RIGHT};
  localparam logic [4:0] CMD_P3_UP    = {1'b0, 2'd2, DIR_UP};
  localparam logic [4:0] CMD_P3_DOWN  = {1'b0, 2'd2, DIR_DOWN};
  localparam logic [4:0] CMD_P3_LEFT  = {1'b0, 2'd2, DIR_LEFT};
  localparam logic [4:0] CMD_P3_RIGHT = {1'b0, 2'd2, DIR_RIGHT};
  localparam logic [4:0] CMD_P4_UP    = {1'b0, 2'd3, DIR_UP};
  localparam logic [4:0] CMD_P4_DOWN  = {1'b0, 2'd3, DIR_DOWN};
  localparam logic [4:0] CMD_P4_LEFT  = {1'b0, 2'd3, DIR_LEFT};
  localparam logic [4:0] CMD_P4_RIGHT = {1'b0, 2'd3, DIR_RIGHT};
  localparam logic [4:0] CMD_RESET    = 5'd16;
  localparam logic [4:0] CMD_IDLE     = 5'd31;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } key_map_t;

  // Lookup key is {extended flag, scan byte}; extended and plain forms are distinct keys.
  function automatic key_map_t key_lookup(input logic ext, input logic [7:0] sc);
    key_map_t km;
    km.hit  = 1'b1;
    km.code = CMD_IDLE;
    case ({ext, sc})
      9'h175:  km.code = CMD_P1_UP;
      9'h172:  km.code = CMD_P1_DOWN;
      9'h16B:  km.code = CMD_P1_LEFT;
      9'h174:  km.code = CMD_P1_RIGHT;
      9'h01D:  km.code = CMD_P2_UP;
      9'h01B:  km.code = CMD_P2_DOWN;
      9'h01C:  km.code = CMD_P2_LEFT;
      9'h023:  km.code = CMD_P2_RIGHT;
      9'h043:  km.code = CMD_P3_UP;
      9'h042:  km.code = CMD_P3_DOWN;
      9'h03B:  km.code = CMD_P3_LEFT;
      9'h04B:  km.code = CMD_P3_RIGHT;
      9'h075:  km.code = CMD_P4_UP;
      9'h073:  km.code = CMD_P4_DOWN;
      9'h06B:  km.code = CMD_P4_LEFT;
      9'h074:  km.code = CMD_P4_RIGHT;
      9'h029:  km.code = CMD_RESET;
      default: km.hit  = 1'b0;
    endcase
    return km;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronise pins, shift 11-bit frames, check start/parity/stop.
// byte_valid strobes one cycle after the 11th falling edge; no backpressure (sink must keep up).
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_byte,
  output logic       byte_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          clk_prev;
  logic [3:0]    bit_cnt;
  logic [10:0]   frame;
  logic [TW-1:0] to_cnt;

  logic          fall;
  logic [10:0]   shifted;
  logic          frame_ok;

  always_comb begin
    fall     = clk_prev & ~clk_s[1];
    shifted  = {dat_s[1], frame[10:1]};
    // start low, stop high, odd parity over data + parity bit
    frame_ok = ~shifted[0] & shifted[10] & (^shifted[9:1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s      <= 2'b11;
      dat_s      <= 2'b11;
      clk_prev   <= 1'b1;
      bit_cnt    <= 4'd0;
      frame      <= 11'd0;
      to_cnt     <= '0;
      scan_byte  <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      clk_s      <= {clk_s[0], ps2_clk};
      dat_s      <= {dat_s[0], ps2_dat};
      clk_prev   <= clk_s[1];
      byte_valid <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        frame  <= shifted;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            scan_byte  <= shifted[8:1];
            byte_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // a stalled partial frame is dropped so the next start bit realigns
        if (to_cnt == TO_LAST) begin
          bit_cnt <= 4'd0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keyboard.sv
// Tron keyboard front end: PS/2 receive, prefix tracking, key map to a 5-bit command.
// KEY_PRESSED updates one cycle after byte_valid; no backpressure.
module keyboard
  import tron_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 8192,
  parameter logic [4:0] IDLE_CODE      = CMD_IDLE
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_KBCLK,
  input  logic       PS2_KBDAT,
  output logic [4:0] KEY_PRESSED,
  output logic [7:0] scan_byte,
  output logic       byte_valid
);

  logic     ext_flag;
  logic     brk_flag;
  key_map_t km;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (CLOCK_50),
    .rst       (reset),
    .ps2_clk   (PS2_KBCLK),
    .ps2_dat   (PS2_KBDAT),
    .scan_byte (scan_byte),
    .byte_valid(byte_valid)
  );

  always_comb begin
    km = key_lookup(ext_flag, scan_byte);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      KEY_PRESSED <= IDLE_CODE;
    end else if (byte_valid) begin
      if (scan_byte == PS2_EXT) begin
        ext_flag <= 1'b1;
      end else if (scan_byte == PS2_BRK) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (km.hit) begin
          if (!brk_flag) begin
            KEY_PRESSED <= km.code;
          end else if (km.code == KEY_PRESSED) begin
            // releasing a key that is no longer the latest make leaves the command alone
            KEY_PRESSED <= IDLE_CODE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keyboard.sv
// Directed bench for keyboard: drives PS/2 frames and checks decoded commands.
module tb_keyboard;

  localparam int HP = 80;

  logic       clk;
  logic       reset;
  logic       kb_clk;
  logic       kb_dat;
  logic [4:0] key_pressed;
  logic [7:0] scan_byte;
  logic       byte_valid;

  int         total = 0;
  int         bad   = 0;
  int         got;
  logic [7:0] got_byte;
  logic [4:0] key_at;
  logic [4:0] key_after;

  keyboard dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .PS2_KBCLK  (kb_clk),
    .PS2_KBDAT  (kb_dat),
    .KEY_PRESSED(key_pressed),
    .scan_byte  (scan_byte),
    .byte_valid (byte_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a frame; during the last bit's low phase it watches the strobe.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    bit          prev;
    f    = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    got  = 0;
    prev = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      repeat (HP / 2) @(posedge clk);
      kb_dat = f[i];
      repeat (HP / 2) @(posedge clk);
      kb_clk = 1'b0;
      if (i == 10) begin
        for (int c = 0; c < HP; c++) begin
          @(negedge clk);
          if (prev) key_after = key_pressed;
          prev = byte_valid;
          if (byte_valid) begin
            got++;
            got_byte = scan_byte;
            key_at   = key_pressed;
          end
        end
      end else begin
        repeat (HP) @(posedge clk);
      end
      kb_clk = 1'b1;
    end
    repeat (HP / 2) @(posedge clk);
    kb_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  initial begin
    reset  = 1'b1;
    kb_clk = 1'b1;
    kb_dat = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_key", key_pressed, 31);
    check("rst_scan", scan_byte, 8'h00);
    check("rst_vld", byte_valid, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    send(8'h1D);
    check("w_strobes", got, 1);
    check("w_byte", got_byte, 8'h1D);
    check("w_key_at_strobe", key_at, 31);
    check("w_key_next", key_after, 4);
    send(8'hF0); send(8'h1D);
    check("w_break", key_pressed, 31);

    send(8'hE0); send(8'h75);
    check("ext_up", key_pressed, 0);
    send(8'h75);
    check("kp8", key_pressed, 12);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_brk_not_cur", key_pressed, 12);
    send(8'hF0); send(8'h75);
    check("kp8_brk", key_pressed, 31);

    send_bits(8'h29, 1'b1, 11);
    check("badpar_strobes", got, 0);
    check("badpar_key", key_pressed, 31);
    send(8'h29);
    check("space", key_pressed, 16);

    send_bits(8'h1D, 1'b0, 5);
    check("partial_cnt", dut.u_rx.bit_cnt, 5);
    repeat (10000) @(posedge clk);
    @(negedge clk);
    check("timeout_cnt", dut.u_rx.bit_cnt, 0);
    send(8'h43);
    check("after_to_strobes", got, 1);
    check("after_to_byte", got_byte, 8'h43);
    check("after_to_key", key_pressed, 8);

    send(8'h23);
    check("d_make1", key_pressed, 7);
    send(8'h23); send(8'h23);
    check("d_repeat", key_pressed, 7);
    send(8'h42);
    check("k_make", key_pressed, 9);
    send(8'hF0); send(8'h23);
    check("d_brk_not_cur", key_pressed, 9);
    send(8'hF0); send(8'h42);
    check("k_brk", key_pressed, 31);

    send(8'h1C);
    check("a_make", key_pressed, 6);
    send_bits(8'h1B, 1'b0, 6);
    check("mid_cnt", dut.u_rx.bit_cnt, 6);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_key", key_pressed, 31);
    check("async_rst_cnt", dut.u_rx.bit_cnt, 0);
    repeat (4) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    send(8'h1B);
    check("post_rst_strobes", got, 1);
    check("post_rst_byte", got_byte, 8'h1B);
    check("post_rst_key", key_pressed, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
